// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and helpers for the BIST sequencer
package bist_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {IDLE, INIT, RUN, FLUSH, COMPARE, DONE} state_t;
  function automatic logic is_busy(input state_t s);
    return s inside {INIT, RUN, FLUSH, COMPARE};
  endfunction
endpackage

// File: rtl/bist_delay_line.sv
// bist_delay_line: DEPTH-cycle delay of a single bit with synchronous clear
module bist_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic din,
  output logic dout
);
  generate
    if (DEPTH == 0) begin : g_wire
      logic unused;
      assign unused = ^{clk, reset, clear};
      assign dout = din;
    end else begin : g_sr
      logic [DEPTH-1:0] sr;
      always_ff @(posedge clk) sr <= (reset || clear) ? '0 : (sr << 1) | DEPTH'(din);
      assign dout = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/bist_controller.sv
// bist_controller: single-session BIST sequencer driving LFSR/SISR enables and signature check
module bist_controller import bist_pkg::*; #(
  parameter int NUM_PATTERNS = 15,
  parameter int CUT_LATENCY = 1,
  parameter int SIG_WIDTH = 4,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = SIG_WIDTH'('hA),
  localparam int CW = $clog2(NUM_PATTERNS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIG_WIDTH-1:0] signature,
  output logic                 test_mode,
  output logic                 gen_clear,
  output logic                 gen_en,
  output logic                 sir_clear,
  output logic                 sir_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CW-1:0]        pat_count
);
  state_t state, state_n;
  logic [2:0] flush_cnt;
  logic kill, last_pat, flush_last;
  assign kill = abort && is_busy(state);
  assign last_pat = pat_count == CW'(NUM_PATTERNS - 1);
  assign flush_last = flush_cnt == 3'(CUT_LATENCY - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? INIT : state;
      INIT:       state_n = RUN;
      RUN:        state_n = last_pat ? (CUT_LATENCY == 0 ? COMPARE : FLUSH) : RUN;
      FLUSH:      state_n = flush_last ? COMPARE : FLUSH;
      COMPARE:    state_n = DONE;
      default:    state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end
  // pat_count and pass drop on entry to INIT so a restart shows them cleared during INIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat_count <= '0;
      flush_cnt <= '0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      pat_count <= state_n == INIT ? '0 : state == RUN ? pat_count + 1'b1 : pat_count;
      flush_cnt <= state == FLUSH ? flush_cnt + 1'b1 : '0;
      pass <= (kill || state_n == INIT) ? 1'b0 : state == COMPARE ? signature == GOLDEN_SIG : pass;
    end
  end
  assign busy = is_busy(state);
  assign test_mode = busy;
  assign gen_clear = state == INIT;
  assign sir_clear = state == INIT;
  assign gen_en = state == RUN;
  assign done = state == DONE;
  bist_delay_line #(.DEPTH(CUT_LATENCY)) u_dly (
    .clk(clk),
    .reset(reset),
    .clear(state == INIT || kill),
    .din(gen_en),
    .dout(sir_en)
  );
endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: directed checks of the BIST sequencer at CUT latency 1 and 0
module tb_bist_controller;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] signature = 4'h0;
  logic test_mode, gen_clear, gen_en, sir_clear, sir_en, busy, done, pass;
  logic [3:0] pat_count;
  logic test_mode0, gen_clear0, gen_en0, sir_clear0, sir_en0, busy0, done0, pass0;
  logic [3:0] pat_count0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bist_controller #(.NUM_PATTERNS(15), .CUT_LATENCY(1), .SIG_WIDTH(4), .GOLDEN_SIG(4'hA)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .signature(signature),
    .test_mode(test_mode), .gen_clear(gen_clear), .gen_en(gen_en), .sir_clear(sir_clear),
    .sir_en(sir_en), .busy(busy), .done(done), .pass(pass), .pat_count(pat_count)
  );

  bist_controller #(.NUM_PATTERNS(15), .CUT_LATENCY(0), .SIG_WIDTH(4), .GOLDEN_SIG(4'hA)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .signature(signature),
    .test_mode(test_mode0), .gen_clear(gen_clear0), .gen_en(gen_en0), .sir_clear(sir_clear0),
    .sir_en(sir_en0), .busy(busy0), .done(done0), .pass(pass0), .pat_count(pat_count0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && !done; i++) tick;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s timeout done=%b exp 1", name, done); end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    tick;
    checks++;
    if ({test_mode, gen_clear, gen_en, sir_clear, sir_en, busy, done, pass, pat_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 000", {test_mode, gen_clear, gen_en, sir_clear, sir_en, busy, done, pass, pat_count});
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    tick;
    checks++;
    if ({busy, done, gen_en} !== 3'b000) begin errors++; $display("FAIL reset_stays_idle got %b exp 000", {busy, done, gen_en}); end
  endtask

  task automatic test_session;
    logic [17:0] gh, sh, bh;
    do_reset;
    signature = 4'hA;
    pulse_start;
    checks++;
    if ({gen_clear, sir_clear, test_mode, busy, gen_en, sir_en, done, pat_count} !== 11'b1111000_0000) begin
      errors++;
      $display("FAIL init_cycle got %b exp 11110000000", {gen_clear, sir_clear, test_mode, busy, gen_en, sir_en, done, pat_count});
    end
    for (int c = 0; c < 18; c++) begin
      tick;
      gh[c] = gen_en; sh[c] = sir_en; bh[c] = busy;
    end
    checks++;
    if (gh !== 18'h07FFF) begin errors++; $display("FAIL gen_en_window got %h exp 07fff", gh); end
    checks++;
    if (sh !== 18'h0FFFE) begin errors++; $display("FAIL sir_en_window got %h exp 0fffe", sh); end
    checks++;
    if (bh !== 18'h1FFFF) begin errors++; $display("FAIL busy_window got %h exp 1ffff", bh); end
    checks++;
    if ({done, pass, test_mode, pat_count} !== 7'b110_1111) begin
      errors++;
      $display("FAIL done_state got %b exp 1101111", {done, pass, test_mode, pat_count});
    end
  endtask

  task automatic test_pass_hold;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if ({done, pass, pat_count} !== 6'b11_1111) begin errors++; $display("FAIL pass_hold got %b exp 111111", {done, pass, pat_count}); end
    end
  endtask

  task automatic test_fail;
    signature = 4'h5;
    pulse_start;
    checks++;
    if ({done, pass, gen_clear, pat_count} !== 7'b001_0000) begin
      errors++;
      $display("FAIL restart_drop got %b exp 0010000", {done, pass, gen_clear, pat_count});
    end
    wait_done("fail_session");
    checks++;
    if ({pass, pat_count} !== 5'b0_1111) begin errors++; $display("FAIL bad_signature got %b exp 01111", {pass, pat_count}); end
  endtask

  task automatic test_abort;
    do_reset;
    signature = 4'hA;
    pulse_start;
    repeat (5) tick;
    checks++;
    if ({gen_en, pat_count} !== 5'b1_0100) begin errors++; $display("FAIL run5_state got %b exp 10100", {gen_en, pat_count}); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({test_mode, gen_en, sir_en, busy, done, pass} !== 6'b000000) begin
      errors++;
      $display("FAIL abort_run got %b exp 000000", {test_mode, gen_en, sir_en, busy, done, pass});
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({busy, done, gen_clear} !== 3'b000) begin errors++; $display("FAIL abort_idle got %b exp 000", {busy, done, gen_clear}); end
    pulse_start;
    wait_done("abort_second_session");
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({done, pass, busy, pat_count} !== 7'b110_1111) begin
      errors++;
      $display("FAIL abort_done got %b exp 1101111", {done, pass, busy, pat_count});
    end
  endtask

  task automatic test_reset_flush;
    int n;
    do_reset;
    signature = 4'hA;
    pulse_start;
    repeat (16) tick;
    checks++;
    if ({busy, gen_en, sir_en} !== 3'b101) begin errors++; $display("FAIL flush_state got %b exp 101", {busy, gen_en, sir_en}); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({test_mode, gen_clear, gen_en, sir_clear, sir_en, busy, done, pass, pat_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_in_flush got %h exp 000", {test_mode, gen_clear, gen_en, sir_clear, sir_en, busy, done, pass, pat_count});
    end
    pulse_start;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick;
      if (gen_en) n++;
    end
    checks++;
    if ({done, pass, pat_count} !== 6'b11_1111 || n != 15) begin
      errors++;
      $display("FAIL post_reset_session got done/pass/cnt %b gen_cycles %0d exp 111111 15", {done, pass, pat_count}, n);
    end
  endtask

  task automatic test_back_to_back;
    start = 1'b1;
    tick;
    checks++;
    if ({done, pass, gen_clear, pat_count} !== 7'b001_0000) begin
      errors++;
      $display("FAIL held_start_init got %b exp 0010000", {done, pass, gen_clear, pat_count});
    end
    tick;
    tick;
    checks++;
    if ({gen_en, busy, pat_count} !== 6'b11_0001) begin
      errors++;
      $display("FAIL start_ignored_run got %b exp 110001", {gen_en, busy, pat_count});
    end
    start = 1'b0;
    wait_done("back_to_back");
    checks++;
    if ({pass, pat_count} !== 5'b1_1111) begin errors++; $display("FAIL back_to_back_end got %b exp 11111", {pass, pat_count}); end
  endtask

  task automatic test_latency0;
    logic [17:0] gh, sh, bh, dh;
    do_reset;
    signature = 4'hA;
    pulse_start;
    checks++;
    if ({gen_clear0, sir_clear0, busy0, gen_en0, sir_en0} !== 5'b11100) begin
      errors++;
      $display("FAIL lat0_init got %b exp 11100", {gen_clear0, sir_clear0, busy0, gen_en0, sir_en0});
    end
    for (int c = 0; c < 18; c++) begin
      tick;
      gh[c] = gen_en0; sh[c] = sir_en0; bh[c] = busy0; dh[c] = done0;
    end
    checks++;
    if (gh !== 18'h07FFF || sh !== 18'h07FFF) begin
      errors++;
      $display("FAIL lat0_enables got gen %h sir %h exp 07fff 07fff", gh, sh);
    end
    checks++;
    if (bh !== 18'h0FFFF || dh !== 18'h30000) begin
      errors++;
      $display("FAIL lat0_no_flush got busy %h done %h exp 0ffff 30000", bh, dh);
    end
    checks++;
    if ({pass0, pat_count0} !== 5'b1_1111) begin errors++; $display("FAIL lat0_result got %b exp 11111", {pass0, pat_count0}); end
  endtask

  initial begin
    test_reset;
    test_session;
    test_pass_hold;
    test_fail;
    test_abort;
    test_reset_flush;
    test_back_to_back;
    test_latency0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
